// File: rtl/sha_ch_sched.sv
// sha_ch_sched: scheduler around a masked SHA-2 Ch gadget.
//
// It accepts share-interleaved operands e/f/g together with fresh randomness
// and feeds them to an external, non-stallable Ch gadget:
//   - f/g are presented first;
//   - e and the randomness follow one cycle later.
// Each operation is tracked by a valid shift register, and the gadget result
// is captured into a small in-order FIFO.
//
// A credit scheme limits how much work can be outstanding. It never admits
// more work than the FIFO can absorb, so the gadget never needs to stall.
//
// Shares are only routed and registered, never combined.
//
// Optional build macro: SHA_CH_ZEROIZE_EN
//   When defined, the gadget drive registers are zeroed in any cycle without
//   a valid operation stage, and out_ch reads 0 while out_valid is low.
module sha_ch_sched #(
    parameter int d          = 2,
    parameter int word       = 13,
    parameter int GAD_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [d*word-1:0]             e_in,
    input  logic [d*word-1:0]             f_in,
    input  logic [d*word-1:0]             g_in,
    input  logic                          rnd_valid,
    output logic                          rnd_ready,
    input  logic [word*d*(d-1)/2-1:0]     rnd_in,
    output logic [d*word-1:0]             gad_e,
    output logic [d*word-1:0]             gad_f,
    output logic [d*word-1:0]             gad_g,
    output logic [word*d*(d-1)/2-1:0]     gad_rnd,
    input  logic [d*word-1:0]             gad_ch,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [d*word-1:0]             out_ch,
    output logic                          busy
);

    localparam int DW    = d * word;
    localparam int RW    = word * d * (d - 1) / 2;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = $clog2(FIFO_DEPTH + GAD_LAT + 2);

    // Valid bit per operation stage: vsr[i] is set in cycle t+1+i for an accept in cycle t.
    logic [GAD_LAT:0]  vsr;
    logic              ready_en;

    // e and randomness wait here one cycle while f/g are on the gadget.
    logic [DW-1:0]     e_q;
    logic [RW-1:0]     rnd_q;

    logic [DW-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic [SUM_W-1:0]  inflight;
    logic              has_credit;
    logic              accept;
    logic              push;
    logic              pop;

    // Count operations still inside the gadget pipeline.
    // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= GAD_LAT; i++) begin
            inflight = inflight + SUM_W'(vsr[i]);
        end
    end

    // Credit is derived only from registered state.
    // A pop therefore frees a slot one cycle later, never combinationally.
    assign has_credit = ready_en && ((SUM_W'(count) + inflight) < SUM_W'(FIFO_DEPTH));
    assign in_ready   = rnd_valid & has_credit;
    assign rnd_ready  = in_valid & has_credit;
    assign accept     = in_valid & rnd_valid & has_credit;

    assign push      = vsr[GAD_LAT];
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign busy      = (|vsr) | out_valid;

    // Hold the handshake off until the first clock edge after reset is released.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Advance the per-operation valid pipeline; reset discards anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsr <= '0;
        end else begin
            vsr <= {vsr[GAD_LAT-1:0], accept};
        end
    end

    // Gadget drive: f/g arrive one cycle after accept, e/rnd one cycle after that.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gad_f   <= '0;
            gad_g   <= '0;
            gad_e   <= '0;
            gad_rnd <= '0;
            e_q     <= '0;
            rnd_q   <= '0;
        end else begin
`ifdef SHA_CH_ZEROIZE_EN
            gad_f   <= accept ? f_in   : '0;
            gad_g   <= accept ? g_in   : '0;
            e_q     <= accept ? e_in   : '0;
            rnd_q   <= accept ? rnd_in : '0;
            gad_e   <= vsr[0] ? e_q    : '0;
            gad_rnd <= vsr[0] ? rnd_q  : '0;
`else
            if (accept) begin
                gad_f <= f_in;
                gad_g <= g_in;
                e_q   <= e_in;
                rnd_q <= rnd_in;
            end
            if (vsr[0]) begin
                gad_e   <= e_q;
                gad_rnd <= rnd_q;
            end
`endif
        end
    end

    // Result FIFO: capture gadget output when an operation reaches the last stage, pop on handshake.
    // NOTE: the small result memory is reset so out_ch reads 0 after reset and no stale shares survive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= gad_ch;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

`ifdef SHA_CH_ZEROIZE_EN
    assign out_ch = out_valid ? mem[rd_ptr] : '0;
`else
    assign out_ch = mem[rd_ptr];
`endif

endmodule
